wordle_guess_engine: RTL
========================

Name: wordle_guess_engine

Overview:
Clocked, parametrised digit-guessing engine for the Wordle game datapath.
- Collects N_DIGITS decimal digits from a strobed digit input to set a secret code, then to enter guesses.
- Rejects codes with repeated digits and evaluates each guess serially, one position per cycle, into a per-position hit/present/miss code.
- Tracks remaining tries and reports win or lose.
- Sits between the switch/debounce front end and the 7-segment/LED display drivers.

Parameters:
N_DIGITS, 5, digits per code (2..8).
DIGIT_W, 4, bits per digit; only values 0..9 are legal.
MAX_TRIES, 9, upper bound on tries per game.
TRY_W, $clog2(MAX_TRIES+1), tries counter width (derived; do not override).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; begins a new game.
tries_cfg  in  TRY_W  try budget, latched on start.
digit_in  in  DIGIT_W  digit value.
digit_valid  in  1  one-cycle strobe qualifying digit_in.
del  in  1  backspace strobe; used only when the optional feature is compiled in.
disp_digits  out  N_DIGITS*DIGIT_W  entry buffer, for the 7-segment display.
tries_left  out  TRY_W  remaining tries.
result  out  2*N_DIGITS  per-slot code: 2'b10 hit, 2'b01 present, 2'b00 miss.
result_valid  out  1  one-cycle pulse when result updates.
dup_warn  out  1  one-cycle pulse when a repeated-digit code is rejected.
bad_digit  out  1  one-cycle pulse when a digit value >9 is rejected.
busy  out  1  high in CHECK and EVAL.
win  out  1  level; high in WIN state.
lose  out  1  level; high in LOSE state.
state_o  out  3  encoded FSM state.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. All outputs and registers reset to 0. FSM resets to IDLE.
- FSM states:
  - IDLE=0, SET=1, ENTRY=2, CHECK_S=3, CHECK_G=4, EVAL=5, WIN=6, LOSE=7.
  - start in any state: clear buffer, pointer, secret, result and used-tries count; latch tries_cfg; go to SET.
  - Tries latch: tries_cfg of 0 is latched as 1; values above MAX_TRIES are latched as MAX_TRIES.
  - start has priority over every other input in the same cycle.
- Digit entry (SET/ENTRY only; ignored in all other states):
  - digit_valid with digit_in<=9: buffer <= {buffer[(N_DIGITS-1)*DIGIT_W-1:0], digit_in}; pointer +1.
  - Slot 0 is the last digit entered; slot k occupies bits [k*DIGIT_W +: DIGIT_W].
  - digit_in>9: bad_digit pulses for 1 cycle; buffer and pointer are unchanged.
  - When the pointer reaches N_DIGITS, the next state is CHECK_S (from SET) or CHECK_G (from ENTRY).
- CHECK_S / CHECK_G (1 cycle):
  - Pairwise compare all slots.
  - Any equal pair: dup_warn pulses; buffer and pointer clear; return to SET or ENTRY respectively.
  - Otherwise CHECK_S copies buffer to secret and goes to ENTRY; CHECK_G copies buffer to guess and goes to EVAL.
  - Buffer and pointer clear on exit in every case.
- EVAL: index j=0..N_DIGITS-1, one slot per cycle.
  - result[2j+:2] = 10 if guess[j]==secret[j]; else 01 if guess[j] equals any secret slot; else 00.
  - result bits for slots not yet evaluated keep their previous values.
- After the last slot, the following cycle:
  - result_valid pulses and used-tries increments.
  - All slots hit: go to WIN.
  - Otherwise, if used == latched budget: go to LOSE.
  - Otherwise go to ENTRY.
- Latency: last digit accepted at edge t; CHECK_G at t+1; EVAL covers t+2..t+N_DIGITS+1; result_valid at t+N_DIGITS+2.
- tries_left = latched budget − used; never underflows. result holds until the next EVAL overwrites it or start clears it.
- WIN/LOSE: sticky until start or reset; digit_valid and del are ignored.
- disp_digits always reflects the entry buffer.
- Reset mid-EVAL: returns immediately to IDLE; no result_valid is produced.

Optional Feature:
WORDLE_BACKSPACE_EN.
- Defined: del in SET/ENTRY with pointer>0 shifts the buffer right by DIGIT_W, zero-fills the top slot, and decrements the pointer. del with pointer==0 has no effect. del and digit_valid in the same cycle: del wins and the digit is dropped.
- Undefined: del is ignored; the port remains present.

Test Plan:
1. Defaults, tries_cfg=3, start; enter 1,2,3,4,5 → disp_digits=0x12345; ENTRY reached 2 cycles after the 5th digit; tries_left=3.
2. Secret 12345; guess 1,3,2,9,5 → result_valid exactly 7 cycles after the 5th digit; result=10'h252; tries_left=2; state ENTRY.
3. Guess 1,1,2,3,4 → dup_warn 1-cycle pulse; tries_left unchanged; buffer 0; no result_valid.
4. digit_in=4'hB in SET → bad_digit pulse; pointer unchanged. Exact guess 12345 → result=10'h2AA; win=1; later digits ignored.
5. tries_cfg=1; one wrong guess → lose=1, tries_left=0. Assert start with digit_valid in the same cycle → state SET, buffer empty.
6. With WORDLE_BACKSPACE_EN: enter 1,2,3 then del → disp_digits=0x00012, pointer 2; del with digit_valid in the same cycle → digit dropped. Without the macro, del has no effect.

Source files
------------

// File: rtl/wordle_guess_engine.sv
// wordle_guess_engine: collects digit codes, rejects repeats, evaluates guesses serially, tracks tries and win/lose
// Ports: clk, rst_n (async active-low); start pulse latches tries_cfg and begins a game;
//   digit_in/digit_valid enter digits, del backspaces (only with WORDLE_BACKSPACE_EN defined);
//   disp_digits shows the entry buffer; result/result_valid give per-slot hit(10)/present(01)/miss(00);
//   dup_warn, bad_digit are one-cycle pulses; busy, win, lose, state_o report FSM status; tries_left counts down.
// Optional feature macro: WORDLE_BACKSPACE_EN.
module wordle_guess_engine #(
    parameter int N_DIGITS  = 5,
    parameter int DIGIT_W   = 4,
    parameter int MAX_TRIES = 9,
    parameter int TRY_W     = $clog2(MAX_TRIES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [TRY_W-1:0]            tries_cfg,
    input  logic [DIGIT_W-1:0]          digit_in,
    input  logic                        digit_valid,
    input  logic                        del,
    output logic [N_DIGITS*DIGIT_W-1:0] disp_digits,
    output logic [TRY_W-1:0]            tries_left,
    output logic [2*N_DIGITS-1:0]       result,
    output logic                        result_valid,
    output logic                        dup_warn,
    output logic                        bad_digit,
    output logic                        busy,
    output logic                        win,
    output logic                        lose,
    output logic [2:0]                  state_o
);
    localparam int BUF_W = N_DIGITS * DIGIT_W;
    localparam int PTR_W = $clog2(N_DIGITS + 1);

    typedef enum logic [2:0] {IDLE, SET, ENTRY, CHECK_S, CHECK_G, EVAL, WIN, LOSE} state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    entry_q, entry_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [BUF_W-1:0]    secret_q, secret_d;
    logic [BUF_W-1:0]    guess_q, guess_d;
    logic [PTR_W-1:0]    idx_q, idx_d;
    logic [2*N_DIGITS-1:0] result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                dup_warn_q, dup_warn_d;
    logic                bad_digit_q, bad_digit_d;
    logic [TRY_W-1:0]    budget_q, budget_d;
    logic [TRY_W-1:0]    used_q, used_d;

    logic                dup, pres, all_hit;
    logic [DIGIT_W-1:0]  g, s;
    logic [2*N_DIGITS-1:0] res_eval;

`ifndef WORDLE_BACKSPACE_EN
    logic unused_del;
    assign unused_del = del;
`endif

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < N_DIGITS; i++)
            for (int k = i + 1; k < N_DIGITS; k++)
                if (entry_q[i*DIGIT_W +: DIGIT_W] == entry_q[k*DIGIT_W +: DIGIT_W]) dup = 1'b1;
        g = guess_q[idx_q*DIGIT_W +: DIGIT_W];
        s = secret_q[idx_q*DIGIT_W +: DIGIT_W];
        pres = 1'b0;
        for (int k = 0; k < N_DIGITS; k++)
            if (secret_q[k*DIGIT_W +: DIGIT_W] == g) pres = 1'b1;
        res_eval = result_q;
        res_eval[idx_q*2 +: 2] = (g == s) ? 2'b10 : pres ? 2'b01 : 2'b00;
        // Win is decided on the final slot's cycle, so it must see that slot's fresh code.
        all_hit = 1'b1;
        for (int k = 0; k < N_DIGITS; k++)
            if (res_eval[2*k +: 2] != 2'b10) all_hit = 1'b0;
        state_d        = state_q;
        entry_d        = entry_q;
        ptr_d          = ptr_q;
        secret_d       = secret_q;
        guess_d        = guess_q;
        idx_d          = idx_q;
        result_d       = result_q;
        budget_d       = budget_q;
        used_d         = used_q;
        result_valid_d = 1'b0;
        dup_warn_d     = 1'b0;
        bad_digit_d    = 1'b0;
        if (start) begin
            state_d  = SET;
            entry_d  = '0;
            ptr_d    = '0;
            secret_d = '0;
            guess_d  = '0;
            idx_d    = '0;
            result_d = '0;
            used_d   = '0;
            budget_d = (tries_cfg == '0) ? TRY_W'(1) :
                       (tries_cfg > TRY_W'(MAX_TRIES)) ? TRY_W'(MAX_TRIES) : tries_cfg;
        end else begin
            case (state_q)
                SET, ENTRY: begin
                    // A full buffer moves to its check state next cycle; further strobes are ignored.
                    if (ptr_q == PTR_W'(N_DIGITS)) begin
                        state_d = (state_q == SET) ? CHECK_S : CHECK_G;
                    end
`ifdef WORDLE_BACKSPACE_EN
                    else if (del) begin
                        if (ptr_q != '0) begin
                            entry_d = {{DIGIT_W{1'b0}}, entry_q[BUF_W-1:DIGIT_W]};
                            ptr_d   = ptr_q - 1'b1;
                        end
                    end
`endif
                    else if (digit_valid) begin
                        if (digit_in > DIGIT_W'(9)) begin
                            bad_digit_d = 1'b1;
                        end else begin
                            entry_d = {entry_q[BUF_W-DIGIT_W-1:0], digit_in};
                            ptr_d   = ptr_q + 1'b1;
                        end
                    end
                end
                CHECK_S, CHECK_G: begin
                    entry_d = '0;
                    ptr_d   = '0;
                    if (dup) begin
                        dup_warn_d = 1'b1;
                        state_d    = (state_q == CHECK_S) ? SET : ENTRY;
                    end else if (state_q == CHECK_S) begin
                        secret_d = entry_q;
                        state_d  = ENTRY;
                    end else begin
                        guess_d = entry_q;
                        idx_d   = '0;
                        state_d = EVAL;
                    end
                end
                EVAL: begin
                    result_d = res_eval;
                    if (idx_q == PTR_W'(N_DIGITS - 1)) begin
                        result_valid_d = 1'b1;
                        used_d         = used_q + 1'b1;
                        state_d        = all_hit ? WIN :
                                         (used_q + 1'b1 == budget_q) ? LOSE : ENTRY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            entry_q        <= '0;
            ptr_q          <= '0;
            secret_q       <= '0;
            guess_q        <= '0;
            idx_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            dup_warn_q     <= 1'b0;
            bad_digit_q    <= 1'b0;
            budget_q       <= '0;
            used_q         <= '0;
        end else begin
            state_q        <= state_d;
            entry_q        <= entry_d;
            ptr_q          <= ptr_d;
            secret_q       <= secret_d;
            guess_q        <= guess_d;
            idx_q          <= idx_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            dup_warn_q     <= dup_warn_d;
            bad_digit_q    <= bad_digit_d;
            budget_q       <= budget_d;
            used_q         <= used_d;
        end
    end

    assign disp_digits  = entry_q;
    assign tries_left   = (used_q > budget_q) ? '0 : budget_q - used_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign dup_warn     = dup_warn_q;
    assign bad_digit    = bad_digit_q;
    assign busy         = (state_q == CHECK_S) || (state_q == CHECK_G) || (state_q == EVAL);
    assign win          = (state_q == WIN);
    assign lose         = (state_q == LOSE);
    assign state_o      = state_q;
endmodule
